ps2_ascii_decoder: RTL and testbench
====================================

Name: ps2_ascii_decoder

Overview:
- Sits directly downstream of the PS/2 keyboard byte receiver. Consumes its scan-code set 2 byte stream (`ps2_code`/`strobe`/`err`).
- Tracks prefix bytes (E0, F0, E1) and modifier state (shift, ctrl, caps lock), and translates make codes to ASCII.
- Buffers characters in a small first-word-fall-through (FWFT) FIFO with a valid/ready handshake, for the j1eforth UART-style input path.

Parameters:
FIFO_DEPTH, 8, output FIFO depth in characters; power of two, 2..64
CW, 4, width of `fifo_count`; must equal log2(FIFO_DEPTH)+1

Ports:
clk  input  1  system clock, same domain as the receiver
resetn  input  1  asynchronous active-low reset
ps2_code  input  8  received scan byte, valid when strobe=1
strobe  input  1  one-cycle pulse: ps2_code holds a new byte
err  input  1  one-cycle pulse: receiver framing/parity error
ascii_data  output  8  head-of-FIFO character
ascii_valid  output  1  FIFO non-empty
ascii_ready  input  1  consumer accepts; pop when valid&ready
shift_held  output  1  either shift currently pressed
ctrl_held  output  1  either ctrl currently pressed
caps_lock  output  1  caps-lock toggle state
overflow  output  1  one-cycle pulse: character dropped, FIFO full
fifo_count  output  CW  characters currently buffered

Behaviour:
- Reset (async, resetn=0): all outputs 0, FIFO empty, modifiers clear, FSM in IDLE, skip counter 0. Mid-sequence reset discards any pending prefix and any partial character.
- Byte handling occurs only on strobe=1. If strobe and err are both 1, err wins and the byte is discarded.
- FSM states: IDLE, EXT (after E0), BRK (after F0), EXT_BRK (after E0 F0), SKIP (pause sequence).
  - IDLE: E0→EXT; F0→BRK; E1→SKIP with count=7; AA, FA, FE, EE, 00, FF are ignored; any other byte is a make code → process, stay IDLE.
  - EXT: F0→EXT_BRK; E0 is ignored; any other byte is an extended make → process, →IDLE.
  - BRK: any byte is a break code → process release, →IDLE.
  - EXT_BRK: any byte is an extended break → process release, →IDLE.
  - SKIP: each byte decrements count; at 0→IDLE. No output and no modifier change.
  - err=1 in any state → IDLE, skip count cleared, modifiers unchanged.
- Modifiers:
  - Shift: 12 and 59 set/clear independent left/right flags; `shift_held` = OR of the two.
  - Ctrl: 14 and E0 14 set/clear left/right flags; `ctrl_held` = OR.
  - Caps lock: 58 make toggles `caps_lock` only on the first make after a break. Typematic repeats are ignored via an internal held flag, cleared by F0 58.
- Translation (non-extended make codes only, except as listed):
  - Letters a–z: 1C 32 21 23 24 2B 34 33 43 3B 42 4B 3A 31 44 4D 15 2D 1B 2C 3C 2A 1D 22 35 1A.
  - Digits 1–9,0: 16 1E 26 25 2E 36 3D 3E 46 45. Shifted: `! @ # $ % ^ & * ( )`.
  - Punctuation, unshifted/shifted: 4E `-`/`_`, 55 `=`/`+`, 54 `[`/`{`, 5B `]`/`}`, 5D `\`/`|`, 4C `;`/`:`, 52 `'`/`"`, 41 `,`/`<`, 49 `.`/`>`, 4A `/`/`?`, 0E `` ` ``/`~`.
  - Control keys: 29→20, 5A→0D, 66→08, 0D→09, 76→1B, 71→7F. Extended: E0 5A→0D, E0 4A→2F, E0 71→7F.
  - Letter case: uppercase iff shift XOR caps. Non-letters use shift only.
  - Ctrl: ctrl_held with a letter yields (uppercase code & 1F); ctrl with any other key yields the normal translation.
  - Unmapped codes and all breaks produce no character.
- Latency: a make code strobed at cycle N is written to the FIFO at the cycle N+1 edge. `ascii_valid`/`ascii_data` reflect it from cycle N+1 when the FIFO was empty (FWFT).
- FIFO rules:
  - Pop on valid&ready.
  - Push+pop in the same cycle is allowed in any occupancy, including full: count is unchanged and no overflow.
  - Push while full without pop: character dropped, `overflow`=1 for 1 cycle, FIFO contents intact.
  - Pop while empty is ignored.
  - Pointers wrap modulo FIFO_DEPTH.
  - `fifo_count` ranges 0..FIFO_DEPTH.

Test Plan:
- Reset, then strobe 1C → `ascii_data`=61 `ascii_valid`=1 at N+1; ready=1 pops, `fifo_count`=0. Then strobe F0,1C → no output.
- 12, 1C, 16, F0 12, 1C → characters 41, 21, 61. `shift_held` 1 then 0.
- 58, 58 (repeat), F0 58, 15, 58, F0 58, 15 → `caps_lock` 1, then 51 (Q), then `caps_lock` 0, then 71.
- E0 14, 21, E0 F0 14, 21 → 03, then 63. E1 14 77 E1 F0 14 F0 77 followed by 29 → only 20 emitted.
- ascii_ready=0, 9 make codes of 1C with FIFO_DEPTH=8 → `fifo_count`=8 and one `overflow` pulse on the 9th. Push+pop while full → count stays 8, no pulse.
- E0 then err pulse then 1C → 61 (prefix aborted). Strobe 1C then resetn low at N → no `ascii_valid`, all outputs 0.

Source files
------------

// File: rtl/ps2_ascii_decoder.sv
// ============================================================================
//  Module      : ps2_ascii_decoder
//  Description : PS/2 scan-code set 2 to ASCII translator with modifier
//                tracking and a first-word-fall-through output FIFO.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module ps2_ascii_decoder #(
    parameter int FIFO_DEPTH = 8,
    parameter int CW         = 4
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic [7:0]    ps2_code,
    input  logic          strobe,
    input  logic          err,
    output logic [7:0]    ascii_data,
    output logic          ascii_valid,
    input  logic          ascii_ready,
    output logic          shift_held,
    output logic          ctrl_held,
    output logic          caps_lock,
    output logic          overflow,
    output logic [CW-1:0] fifo_count
);

    localparam int AW = CW - 1;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_EXT     = 3'd1;
    localparam logic [2:0] S_BRK     = 3'd2;
    localparam logic [2:0] S_EXT_BRK = 3'd3;
    localparam logic [2:0] S_SKIP    = 3'd4;

    localparam logic [7:0] c_pfx_ext   = 8'hE0;
    localparam logic [7:0] c_pfx_brk   = 8'hF0;
    localparam logic [7:0] c_pfx_pause = 8'hE1;

    logic [2:0]      r_state, w_state_nxt;
    logic [2:0]      r_skip_cnt, w_skip_nxt;
    logic            w_make, w_break, w_ext;
    logic            w_mapped, w_is_letter;
    logic [7:0]      w_base, w_shifted, w_upper, w_char;
    logic            w_push, w_pop, w_wr, w_full, w_empty;
    logic            r_lshift, r_rshift, r_lctrl, r_rctrl, r_caps, r_caps_held;
    logic            r_overflow;
    logic [7:0]      r_mem [FIFO_DEPTH];
    logic [AW-1:0]   r_wr_ptr, r_rd_ptr;
    logic [CW-1:0]   r_count;

    // ------------------------------------------------------------------
    // Prefix FSM: state register, next-state logic, event decode
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state    <= S_IDLE;
            r_skip_cnt <= 3'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_skip_cnt <= w_skip_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_skip_nxt  = r_skip_cnt;
        if (err) begin
            w_state_nxt = S_IDLE;
            w_skip_nxt  = 3'd0;
        end else if (strobe) begin
            case (r_state)
                S_IDLE: begin
                    if (ps2_code == c_pfx_ext) begin
                        w_state_nxt = S_EXT;
                    end else if (ps2_code == c_pfx_brk) begin
                        w_state_nxt = S_BRK;
                    end else if (ps2_code == c_pfx_pause) begin
                        w_state_nxt = S_SKIP;
                        w_skip_nxt  = 3'd7;
                    end
                end
                S_EXT: begin
                    if (ps2_code == c_pfx_brk)
                        w_state_nxt = S_EXT_BRK;
                    else if (ps2_code != c_pfx_ext)
                        w_state_nxt = S_IDLE;
                end
                S_BRK, S_EXT_BRK: w_state_nxt = S_IDLE;
                S_SKIP: begin
                    w_skip_nxt = r_skip_cnt - 3'd1;
                    if (r_skip_cnt <= 3'd1) begin
                        w_state_nxt = S_IDLE;
                        w_skip_nxt  = 3'd0;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        w_make  = 1'b0;
        w_break = 1'b0;
        w_ext   = 1'b0;
        if (strobe && !err) begin
            case (r_state)
                S_IDLE: w_make = !(ps2_code inside {c_pfx_ext, c_pfx_brk, c_pfx_pause,
                                                    8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF});
                S_EXT: begin
                    w_ext  = 1'b1;
                    w_make = (ps2_code != c_pfx_brk) && (ps2_code != c_pfx_ext);
                end
                S_BRK:     w_break = 1'b1;
                S_EXT_BRK: begin
                    w_ext   = 1'b1;
                    w_break = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Scan code lookup: lowercase/unshifted and shifted forms
    // ------------------------------------------------------------------
    always_comb begin
        w_mapped    = 1'b1;
        w_is_letter = 1'b0;
        w_base      = 8'h00;
        w_shifted   = 8'h00;
        if (w_ext) begin
            case (ps2_code)
                8'h5A:   w_base = 8'h0D;
                8'h4A:   w_base = 8'h2F;
                8'h71:   w_base = 8'h7F;
                default: w_mapped = 1'b0;
            endcase
            w_shifted = w_base;
        end else begin
            case (ps2_code)
                8'h1C: begin w_is_letter = 1'b1; w_base = "a"; end
                8'h32: begin w_is_letter = 1'b1; w_base = "b"; end
                8'h21: begin w_is_letter = 1'b1; w_base = "c"; end
                8'h23: begin w_is_letter = 1'b1; w_base = "d"; end
                8'h24: begin w_is_letter = 1'b1; w_base = "e"; end
                8'h2B: begin w_is_letter = 1'b1; w_base = "f"; end
                8'h34: begin w_is_letter = 1'b1; w_base = "g"; end
                8'h33: begin w_is_letter = 1'b1; w_base = "h"; end
                8'h43: begin w_is_letter = 1'b1; w_base = "i"; end
                8'h3B: begin w_is_letter = 1'b1; w_base = "j"; end
                8'h42: begin w_is_letter = 1'b1; w_base = "k"; end
                8'h4B: begin w_is_letter = 1'b1; w_base = "l"; end
                8'h3A: begin w_is_letter = 1'b1; w_base = "m"; end
                8'h31: begin w_is_letter = 1'b1; w_base = "n"; end
                8'h44: begin w_is_letter = 1'b1; w_base = "o"; end
                8'h4D: begin w_is_letter = 1'b1; w_base = "p"; end
                8'h15: begin w_is_letter = 1'b1; w_base = "q"; end
                8'h2D: begin w_is_letter = 1'b1; w_base = "r"; end
                8'h1B: begin w_is_letter = 1'b1; w_base = "s"; end
                8'h2C: begin w_is_letter = 1'b1; w_base = "t"; end
                8'h3C: begin w_is_letter = 1'b1; w_base = "u"; end
                8'h2A: begin w_is_letter = 1'b1; w_base = "v"; end
                8'h1D: begin w_is_letter = 1'b1; w_base = "w"; end
                8'h22: begin w_is_letter = 1'b1; w_base = "x"; end
                8'h35: begin w_is_letter = 1'b1; w_base = "y"; end
                8'h1A: begin w_is_letter = 1'b1; w_base = "z"; end
                8'h16: begin w_base = "1";  w_shifted = "!"; end
                8'h1E: begin w_base = "2";  w_shifted = "@"; end
                8'h26: begin w_base = "3";  w_shifted = "#"; end
                8'h25: begin w_base = "4";  w_shifted = "$"; end
                8'h2E: begin w_base = "5";  w_shifted = "%"; end
                8'h36: begin w_base = "6";  w_shifted = "^"; end
                8'h3D: begin w_base = "7";  w_shifted = "&"; end
                8'h3E: begin w_base = "8";  w_shifted = "*"; end
                8'h46: begin w_base = "9";  w_shifted = "("; end
                8'h45: begin w_base = "0";  w_shifted = ")"; end
                8'h4E: begin w_base = "-";  w_shifted = "_"; end
                8'h55: begin w_base = "=";  w_shifted = "+"; end
                8'h54: begin w_base = "[";  w_shifted = "{"; end
                8'h5B: begin w_base = "]";  w_shifted = "}"; end
                8'h5D: begin w_base = "\\"; w_shifted = "|"; end
                8'h4C: begin w_base = ";";  w_shifted = ":"; end
                8'h52: begin w_base = "'";  w_shifted = "\""; end
                8'h41: begin w_base = ",";  w_shifted = "<"; end
                8'h49: begin w_base = ".";  w_shifted = ">"; end
                8'h4A: begin w_base = "/";  w_shifted = "?"; end
                8'h0E: begin w_base = 8'h60; w_shifted = "~"; end
                8'h29: begin w_base = 8'h20; w_shifted = 8'h20; end
                8'h5A: begin w_base = 8'h0D; w_shifted = 8'h0D; end
                8'h66: begin w_base = 8'h08; w_shifted = 8'h08; end
                8'h0D: begin w_base = 8'h09; w_shifted = 8'h09; end
                8'h76: begin w_base = 8'h1B; w_shifted = 8'h1B; end
                8'h71: begin w_base = 8'h7F; w_shifted = 8'h7F; end
                default: w_mapped = 1'b0;
            endcase
        end
    end

    // Ctrl only folds letters; everything else keeps its plain translation
    always_comb begin
        w_upper = w_base & 8'hDF;
        w_char  = shift_held ? w_shifted : w_base;
        if (w_is_letter) begin
            if (ctrl_held)
                w_char = w_upper & 8'h1F;
            else
                w_char = (shift_held ^ caps_lock) ? w_upper : w_base;
        end
        w_push = w_make & w_mapped;
    end

    // ------------------------------------------------------------------
    // Modifier tracking
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_lshift    <= 1'b0;
            r_rshift    <= 1'b0;
            r_lctrl     <= 1'b0;
            r_rctrl     <= 1'b0;
            r_caps      <= 1'b0;
            r_caps_held <= 1'b0;
        end else if (w_make || w_break) begin
            if (w_ext) begin
                if (ps2_code == 8'h14)
                    r_rctrl <= w_make;
            end else begin
                case (ps2_code)
                    8'h12: r_lshift <= w_make;
                    8'h59: r_rshift <= w_make;
                    8'h14: r_lctrl  <= w_make;
                    8'h58: begin
                        // typematic repeats of caps lock must not re-toggle
                        if (w_make && !r_caps_held)
                            r_caps <= ~r_caps;
                        r_caps_held <= w_make;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign shift_held = r_lshift | r_rshift;
    assign ctrl_held  = r_lctrl | r_rctrl;
    assign caps_lock  = r_caps;

    // ------------------------------------------------------------------
    // Output FIFO (first-word fall-through)
    // ------------------------------------------------------------------
    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CW'(FIFO_DEPTH));
    assign w_pop   = !w_empty && ascii_ready;
    assign w_wr    = w_push && (!w_full || w_pop);

    always_ff @(posedge clk) begin
        if (w_wr)
            r_mem[r_wr_ptr] <= w_char;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_overflow <= w_push && w_full && !w_pop;
            if (w_wr)
                r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: ;
            endcase
        end
    end

    assign ascii_valid = !w_empty;
    assign ascii_data  = w_empty ? 8'h00 : r_mem[r_rd_ptr];
    assign overflow    = r_overflow;
    assign fifo_count  = r_count;

endmodule

`default_nettype wire

// File: tb/tb_ps2_ascii_decoder.sv
// ============================================================================
//  Module      : tb_ps2_ascii_decoder
//  Description : Directed scoreboard bench for ps2_ascii_decoder.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ps2_ascii_decoder;

    logic       clk = 1'b0;
    logic       resetn;
    logic [7:0] ps2_code;
    logic       strobe;
    logic       err;
    logic [7:0] ascii_data;
    logic       ascii_valid;
    logic       ascii_ready;
    logic       shift_held;
    logic       ctrl_held;
    logic       caps_lock;
    logic       overflow;
    logic [3:0] fifo_count;

    int vectors     = 0;
    int miscompares = 0;
    logic [7:0] exp_q[$];

    ps2_ascii_decoder #(.FIFO_DEPTH(8), .CW(4)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .ps2_code    (ps2_code),
        .strobe      (strobe),
        .err         (err),
        .ascii_data  (ascii_data),
        .ascii_valid (ascii_valid),
        .ascii_ready (ascii_ready),
        .shift_held  (shift_held),
        .ctrl_held   (ctrl_held),
        .caps_lock   (caps_lock),
        .overflow    (overflow),
        .fifo_count  (fifo_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Consumer side: every accepted character must match the scoreboard head
    always @(negedge clk) begin
        if (resetn === 1'b1 && ascii_valid === 1'b1 && ascii_ready === 1'b1) begin
            vectors++;
            assert (exp_q.size() != 0) else begin
                miscompares++;
                $error("FAIL spurious_char: observed %0h expected none", ascii_data);
            end
            if (exp_q.size() != 0)
                check("char", 32'(ascii_data), 32'(exp_q.pop_front()));
        end
    end

    task automatic send(input logic [7:0] b);
        ps2_code = b;
        strobe   = 1'b1;
        @(posedge clk); #1;
        strobe   = 1'b0;
    endtask

    task automatic key(input logic [7:0] b, input logic [7:0] exp);
        exp_q.push_back(exp);
        send(b);
    endtask

    task automatic pulse_err();
        err = 1'b1;
        @(posedge clk); #1;
        err = 1'b0;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(posedge clk);
        repeat (3) @(posedge clk);
        #1;
        check({"drain_", tag}, 32'(exp_q.size()), 32'd0);
        check({"idle_valid_", tag}, 32'(ascii_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn      = 1'b0;
        ps2_code    = 8'h00;
        strobe      = 1'b0;
        err         = 1'b0;
        ascii_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid",    32'(ascii_valid), 32'd0);
        check("rst_data",     32'(ascii_data),  32'd0);
        check("rst_count",    32'(fifo_count),  32'd0);
        check("rst_mods",     32'({shift_held, ctrl_held, caps_lock}), 32'd0);
        check("rst_overflow", 32'(overflow),    32'd0);
        resetn = 1'b1;
        @(posedge clk); #1;

        // Basic make, FWFT latency, pop, then a break that emits nothing
        key(8'h1C, 8'h61);
        check("fwft_valid", 32'(ascii_valid), 32'd1);
        check("fwft_data",  32'(ascii_data),  32'h61);
        @(posedge clk); #1;
        check("pop_count",  32'(fifo_count),  32'd0);
        send(8'hF0); send(8'h1C);
        drain("basic");

        // Shift
        send(8'h12);
        check("shift_on", 32'(shift_held), 32'd1);
        key(8'h1C, 8'h41);
        key(8'h16, 8'h21);
        key(8'h52, 8'h22);
        send(8'hF0); send(8'h12);
        check("shift_off", 32'(shift_held), 32'd0);
        key(8'h1C, 8'h61);
        key(8'h4E, 8'h2D);
        drain("shift");

        // Caps lock with typematic repeat
        send(8'h58);
        check("caps_on", 32'(caps_lock), 32'd1);
        send(8'h58);
        check("caps_repeat", 32'(caps_lock), 32'd1);
        send(8'hF0); send(8'h58);
        key(8'h15, 8'h51);
        send(8'h58); send(8'hF0); send(8'h58);
        check("caps_off", 32'(caps_lock), 32'd0);
        key(8'h15, 8'h71);
        drain("caps");

        // Right ctrl, extended keys, pause sequence skip
        send(8'hE0); send(8'h14);
        check("rctrl_on", 32'(ctrl_held), 32'd1);
        key(8'h21, 8'h03);
        key(8'h16, 8'h31);
        send(8'hE0); send(8'hF0); send(8'h14);
        check("rctrl_off", 32'(ctrl_held), 32'd0);
        key(8'h21, 8'h63);
        send(8'hE0); key(8'h4A, 8'h2F);
        send(8'hE0); key(8'h5A, 8'h0D);
        send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
        send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
        key(8'h29, 8'h20);
        drain("ctrl_pause");

        // Fill to full, overflow on the ninth, then push+pop while full
        ascii_ready = 1'b0;
        key(8'h1C, "a"); key(8'h32, "b"); key(8'h21, "c"); key(8'h23, "d");
        key(8'h24, "e"); key(8'h2B, "f"); key(8'h34, "g"); key(8'h33, "h");
        check("full_count", 32'(fifo_count), 32'd8);
        check("no_ovf_yet", 32'(overflow),   32'd0);
        send(8'h43);
        check("ovf_pulse",  32'(overflow),   32'd1);
        check("ovf_count",  32'(fifo_count), 32'd8);
        @(posedge clk); #1;
        check("ovf_single", 32'(overflow),   32'd0);
        ascii_ready = 1'b1;
        key(8'h3B, "j");
        check("pp_full_count", 32'(fifo_count), 32'd8);
        check("pp_full_ovf",   32'(overflow),   32'd0);
        drain("overflow");

        // Error aborts a pending prefix
        send(8'hE0);
        pulse_err();
        key(8'h1C, 8'h61);
        send(8'hF0);
        ps2_code = 8'h1C; strobe = 1'b1; err = 1'b1;
        @(posedge clk); #1;
        strobe = 1'b0; err = 1'b0;
        key(8'h32, 8'h62);
        drain("err");

        // Reset mid-sequence discards modifiers, prefix and the in-flight byte
        send(8'h12);
        send(8'hF0);
        ps2_code = 8'h1C; strobe = 1'b1; resetn = 1'b0;
        @(posedge clk); #1;
        strobe = 1'b0;
        check("midrst_valid", 32'(ascii_valid), 32'd0);
        check("midrst_outs",  32'({ascii_data, shift_held, ctrl_held, caps_lock, overflow, fifo_count}), 32'd0);
        resetn = 1'b1;
        @(posedge clk); #1;
        check("postrst_valid", 32'(ascii_valid), 32'd0);
        key(8'h1C, 8'h61);
        drain("midrst");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
